// File: rtl/priority_mux_arb.sv
// -----------------------------------------------------------------------------
// priority_mux_arb
//
// Registered, handshaked priority mux. Arbitrates CNT valid/ready request
// channels (fixed lowest-index or round-robin priority, picked at run time by
// rr_mode) and captures the winning word into a single output register with a
// valid/ready interface. Full throughput: the output register can drain and
// reload in the same cycle.
//
// Parameters
//   WIDTH   data width per channel
//   CNT     number of request channels (>= 2)
//   PTR_W   round-robin pointer width, derived from CNT (leave at default)
//
// Ports
//   clk        clock
//   rst_n      synchronous active-low reset
//   lock       (only with PRIORITY_MUX_ARB_LOCK_EN) hold grant on the
//              current channel across transfers while high
//   rr_mode    0 = fixed priority (lowest index wins), 1 = round-robin
//   din        per-channel data
//   din_vld    per-channel request valid
//   din_rdy    per-channel accept, at most one bit high
//   dout       registered selected data
//   dout_vld   output register holds valid data
//   dout_rdy   downstream accepts dout
//   dout_gnt   one-hot index of the channel that sourced dout
//
// Build option
//   PRIORITY_MUX_ARB_LOCK_EN  adds the lock input and channel-lock logic.
// -----------------------------------------------------------------------------
module priority_mux_arb #(
   parameter int WIDTH = 32,
   parameter int CNT   = 5,
   parameter int PTR_W = $clog2(CNT)
) (
   input  logic                       clk,
   input  logic                       rst_n,
`ifdef PRIORITY_MUX_ARB_LOCK_EN
   input  logic                       lock,
`endif
   input  logic                       rr_mode,
   input  logic [CNT-1:0][WIDTH-1:0]  din,
   input  logic [CNT-1:0]             din_vld,
   output logic [CNT-1:0]             din_rdy,
   output logic [WIDTH-1:0]           dout,
   output logic                       dout_vld,
   input  logic                       dout_rdy,
   output logic [CNT-1:0]             dout_gnt
);

   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(CNT - 1);

   logic [WIDTH-1:0] dout_q,     dout_d;
   logic             dout_vld_q, dout_vld_d;
   logic [CNT-1:0]   dout_gnt_q, dout_gnt_d;
   logic [PTR_W-1:0] rr_ptr_q,   rr_ptr_d;
`ifdef PRIORITY_MUX_ARB_LOCK_EN
   logic             lock_act_q, lock_act_d;
   logic [PTR_W-1:0] lock_idx_q, lock_idx_d;
`endif

   logic             load;
   logic             found;
   logic [PTR_W-1:0] gnt_idx;
   logic [CNT-1:0]   gnt;
   logic             xfer;

   // Output register is free when empty or being drained this cycle.
   assign load = ~dout_vld_q | dout_rdy;

   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      gnt     = '0;
      if (!rr_mode) begin
         for (int i = 0; i < CNT; i++) begin
            if (!found && din_vld[i]) begin
               found   = 1'b1;
               gnt_idx = PTR_W'(i);
            end
         end
      end else begin
         // Search upward from rr_ptr, wrapping past CNT-1 back to 0.
         for (int k = 0; k < CNT; k++) begin
            if (!found && din_vld[(int'(rr_ptr_q) + k) % CNT]) begin
               found   = 1'b1;
               gnt_idx = PTR_W'((int'(rr_ptr_q) + k) % CNT);
            end
         end
      end
`ifdef PRIORITY_MUX_ARB_LOCK_EN
      // A locked channel owns the grant; everyone else waits even if it idles.
      if (lock_act_q) begin
         found   = din_vld[lock_idx_q];
         gnt_idx = lock_idx_q;
      end
`endif
      if (found) begin
         gnt[gnt_idx] = 1'b1;
      end
   end

   // rst_n gates ready so no requester sees a handshake during reset.
   assign din_rdy = gnt & {CNT{load & rst_n}};
   assign xfer    = |din_rdy;

   always_comb begin
      dout_d     = dout_q;
      dout_vld_d = dout_vld_q;
      dout_gnt_d = dout_gnt_q;
      rr_ptr_d   = rr_ptr_q;
`ifdef PRIORITY_MUX_ARB_LOCK_EN
      lock_act_d = lock_act_q;
      lock_idx_d = lock_idx_q;
`endif
      if (load) begin
         dout_vld_d = xfer;
      end
      if (xfer) begin
         dout_d     = din[gnt_idx];
         dout_gnt_d = gnt;
         rr_ptr_d   = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
`ifdef PRIORITY_MUX_ARB_LOCK_EN
         lock_act_d = lock;
         lock_idx_d = gnt_idx;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dout_q     <= '0;
         dout_vld_q <= 1'b0;
         dout_gnt_q <= '0;
         rr_ptr_q   <= '0;
`ifdef PRIORITY_MUX_ARB_LOCK_EN
         lock_act_q <= 1'b0;
         lock_idx_q <= '0;
`endif
      end else begin
         dout_q     <= dout_d;
         dout_vld_q <= dout_vld_d;
         dout_gnt_q <= dout_gnt_d;
         rr_ptr_q   <= rr_ptr_d;
`ifdef PRIORITY_MUX_ARB_LOCK_EN
         lock_act_q <= lock_act_d;
         lock_idx_q <= lock_idx_d;
`endif
      end
   end

   assign dout     = dout_q;
   assign dout_vld = dout_vld_q;
   assign dout_gnt = dout_gnt_q;

endmodule

// File: tb/tb_priority_mux_arb.sv
module tb_priority_mux_arb;

   localparam int WIDTH = 8;
   localparam int CNT   = 4;

   logic                      clk      = 1'b0;
   logic                      rst_n    = 1'b0;
   logic                      rr_mode  = 1'b0;
   logic [CNT-1:0][WIDTH-1:0] din;
   logic [CNT-1:0]            din_vld  = '0;
   logic [CNT-1:0]            din_rdy;
   logic [WIDTH-1:0]          dout;
   logic                      dout_vld;
   logic                      dout_rdy = 1'b0;
   logic [CNT-1:0]            dout_gnt;
`ifdef PRIORITY_MUX_ARB_LOCK_EN
   logic                      lock     = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   priority_mux_arb #(.WIDTH(WIDTH), .CNT(CNT)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
`ifdef PRIORITY_MUX_ARB_LOCK_EN
      .lock     (lock),
`endif
      .rr_mode  (rr_mode),
      .din      (din),
      .din_vld  (din_vld),
      .din_rdy  (din_rdy),
      .dout     (dout),
      .dout_vld (dout_vld),
      .dout_rdy (dout_rdy),
      .dout_gnt (dout_gnt)
   );

   typedef struct {
      logic       rst;
      logic       mode;
      logic [3:0] vld;
      logic       rdy;
      logic [3:0] e_rdy;   // din_rdy expected during this cycle
      logic       e_vld;   // registered outputs expected after the edge
      logic [7:0] e_dout;
      logic [3:0] e_gnt;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic m, input logic [3:0] v,
                      input logic d, input logic [3:0] er, input logic ev,
                      input logic [7:0] ed, input logic [3:0] eg);
      vec_t t;
      t.rst = r; t.mode = m; t.vld = v; t.rdy = d;
      t.e_rdy = er; t.e_vld = ev; t.e_dout = ed; t.e_gnt = eg;
      vecs.push_back(t);
   endtask

   task automatic step(input int n, input vec_t t);
      @(negedge clk);
      rst_n    = t.rst;
      rr_mode  = t.mode;
      din_vld  = t.vld;
      dout_rdy = t.rdy;
      #1;
      checks++;
      if (din_rdy !== t.e_rdy) begin
         errors++;
         $display("FAIL step%0d din_rdy: got %b expected %b", n, din_rdy, t.e_rdy);
      end
      @(posedge clk);
      #1;
      checks++;
      if (dout_vld !== t.e_vld) begin
         errors++;
         $display("FAIL step%0d dout_vld: got %b expected %b", n, dout_vld, t.e_vld);
      end
      checks++;
      if (dout !== t.e_dout || dout_gnt !== t.e_gnt) begin
         errors++;
         $display("FAIL step%0d dout/dout_gnt: got %h/%b expected %h/%b",
                  n, dout, dout_gnt, t.e_dout, t.e_gnt);
      end
   endtask

   initial begin
      din[0] = 8'h5A;
      din[1] = 8'h11;
      din[2] = 8'h22;
      din[3] = 8'h33;

      //    rst  mode vld    rdy   e_rdy  e_vld e_dout e_gnt
      // reset held two cycles with all channels requesting
      add(1'b0, 1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 8'h00, 4'h0);
      add(1'b0, 1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 8'h00, 4'h0);
      add(1'b1, 1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 8'h5A, 4'h1);  // ptr->1
      // fixed priority, channels 1 and 3 valid
      add(1'b1, 1'b0, 4'hA, 1'b1, 4'h2, 1'b1, 8'h11, 4'h2);  // ptr->2
      add(1'b1, 1'b0, 4'hA, 1'b1, 4'h2, 1'b1, 8'h11, 4'h2);
      add(1'b1, 1'b0, 4'hA, 1'b1, 4'h2, 1'b1, 8'h11, 4'h2);
      // reset, then round-robin with all valid
      add(1'b0, 1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 8'h00, 4'h0);  // ptr->0
      add(1'b1, 1'b1, 4'hF, 1'b1, 4'h1, 1'b1, 8'h5A, 4'h1);
      add(1'b1, 1'b1, 4'hF, 1'b1, 4'h2, 1'b1, 8'h11, 4'h2);
      add(1'b1, 1'b1, 4'hF, 1'b1, 4'h4, 1'b1, 8'h22, 4'h4);
      add(1'b1, 1'b1, 4'hF, 1'b1, 4'h8, 1'b1, 8'h33, 4'h8);
      add(1'b1, 1'b1, 4'hF, 1'b1, 4'h1, 1'b1, 8'h5A, 4'h1);  // ptr->1
      add(1'b1, 1'b1, 4'hF, 1'b1, 4'h2, 1'b1, 8'h11, 4'h2);  // ptr->2
      add(1'b1, 1'b1, 4'hF, 1'b1, 4'h4, 1'b1, 8'h22, 4'h4);  // ptr->3
      // stall three cycles holding channel 2's word; mode flips mid-stall
      add(1'b1, 1'b1, 4'hF, 1'b0, 4'h0, 1'b1, 8'h22, 4'h4);
      add(1'b1, 1'b1, 4'hF, 1'b0, 4'h0, 1'b1, 8'h22, 4'h4);
      add(1'b1, 1'b0, 4'hF, 1'b0, 4'h0, 1'b1, 8'h22, 4'h4);
      // drain and reload in the same cycle
      add(1'b1, 1'b1, 4'hF, 1'b1, 4'h8, 1'b1, 8'h33, 4'h8);  // ptr->0
      add(1'b1, 1'b1, 4'h4, 1'b1, 4'h4, 1'b1, 8'h22, 4'h4);  // ptr->3
      // wrap: ptr=3, only channel 0 valid
      add(1'b1, 1'b1, 4'h1, 1'b1, 4'h1, 1'b1, 8'h5A, 4'h1);  // ptr->1
      add(1'b1, 1'b1, 4'hB, 1'b1, 4'h2, 1'b1, 8'h11, 4'h2);  // ptr->2
      // idle: output empties, dout/dout_gnt hold
      add(1'b1, 1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 8'h11, 4'h2);
      add(1'b1, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 8'h11, 4'h2);
      // empty register loads even with dout_rdy low
      add(1'b1, 1'b0, 4'hC, 1'b0, 4'h4, 1'b1, 8'h22, 4'h4);  // ptr->3
      add(1'b1, 1'b1, 4'hD, 1'b1, 4'h8, 1'b1, 8'h33, 4'h8);  // ptr->0
      add(1'b1, 1'b1, 4'hD, 1'b1, 4'h1, 1'b1, 8'h5A, 4'h1);  // ptr->1
      add(1'b1, 1'b1, 4'hD, 1'b1, 4'h4, 1'b1, 8'h22, 4'h4);  // ptr->3
      add(1'b1, 1'b0, 4'hD, 1'b1, 4'h1, 1'b1, 8'h5A, 4'h1);  // ptr->1
      // reset mid-stall discards the held word
      add(1'b1, 1'b0, 4'h8, 1'b0, 4'h0, 1'b1, 8'h5A, 4'h1);
      add(1'b0, 1'b0, 4'h8, 1'b0, 4'h0, 1'b0, 8'h00, 4'h0);
      add(1'b1, 1'b1, 4'h8, 1'b0, 4'h8, 1'b1, 8'h33, 4'h8);  // ptr->0

      foreach (vecs[i]) step(i, vecs[i]);

`ifdef PRIORITY_MUX_ARB_LOCK_EN
      begin
         vec_t t;
         // reset, then steer rr_ptr to 2 through a channel-1 transfer
         add(1'b0, 1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 8'h00, 4'h0);
         add(1'b1, 1'b1, 4'h2, 1'b1, 4'h2, 1'b1, 8'h11, 4'h2);
         step(100, vecs[vecs.size()-2]);
         step(101, vecs[vecs.size()-1]);
         // three locked beats from channel 2 while 0 and 3 request
         lock = 1'b1;
         t = vecs[0];
         t.rst = 1'b1; t.mode = 1'b1; t.vld = 4'hD; t.rdy = 1'b1;
         t.e_rdy = 4'h4; t.e_vld = 1'b1; t.e_dout = 8'h22; t.e_gnt = 4'h4;
         step(102, t);
         step(103, t);
         step(104, t);
         // releasing beat still comes from channel 2
         lock = 1'b0;
         step(105, t);
         // lock gone, rr_ptr=3 picks channel 3
         t.e_rdy = 4'h8; t.e_dout = 8'h33; t.e_gnt = 4'h8;
         step(106, t);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/priority_mux_arb.md
Name: priority_mux_arb

Overview:
- Registered, handshaked successor to the combinational priority mux.
- Selects one of CNT valid/ready request channels, using either fixed lowest-index priority or round-robin priority, chosen at run time.
- Captures the selected word into a single output register with a valid/ready interface.
- Sits between multiple register-access sources and one shared downstream consumer. Supports full throughput and back-pressure.

Parameters:
- WIDTH, 32, data width per channel.
- CNT, 5, number of request channels (>=2).
- PTR_W, $clog2(CNT), width of the round-robin pointer. Derived; do not override.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- rr_mode  input  1  0 = fixed priority (lowest index wins); 1 = round-robin.
- din  input  [CNT-1:0][WIDTH-1:0]  per-channel data.
- din_vld  input  CNT  per-channel request valid.
- din_rdy  output  CNT  per-channel accept; at most one bit high.
- dout  output  WIDTH  registered selected data.
- dout_vld  output  1  output register holds valid data.
- dout_rdy  input  1  downstream accepts dout.
- dout_gnt  output  CNT  one-hot index of the channel that sourced dout.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values: dout_vld=0, dout=0, dout_gnt=0, rr_ptr=0, lock state cleared. din_rdy=0 while rst_n=0.
- Load condition: load = ~dout_vld | dout_rdy, meaning the output register is empty or is being drained this cycle.
- Grant vector gnt (combinational, one-hot or zero):
  - Fixed mode: the lowest set index of din_vld.
  - RR mode: the first set bit of din_vld searched from index rr_ptr upward, wrapping from CNT-1 to 0.
- Ready: din_rdy = gnt & {CNT{load}}. A transfer on channel i is din_vld[i] & din_rdy[i].
- On a transfer: dout<=din[i], dout_gnt<=gnt, dout_vld<=1. Latency is 1 cycle from transfer to dout_vld.
- On load with no request: dout_vld<=0. dout and dout_gnt hold their last values.
- Stall (dout_vld=1, dout_rdy=0): dout, dout_vld and dout_gnt hold. All din_rdy=0. Requesters must hold din_vld and din stable.
- Simultaneous drain and new transfer in the same cycle: both occur. Back-to-back transfers give 1 word/cycle.
- rr_ptr update: on each transfer, rr_ptr <= (granted index + 1), wrapping CNT-1 -> 0. It updates in both modes.
- rr_ptr does not move when there is no transfer.
- Mode switching: rr_mode is sampled combinationally each cycle. A switch mid-stall affects only the next arbitration; the held dout is unaffected.
- No requests: gnt=0, din_rdy=0.
- Single requester: granted every load cycle regardless of rr_ptr.
- Reset asserted mid-stall: the held word is discarded and dout_vld=0 on the next cycle.
- Invariant: dout_gnt is one-hot whenever dout_vld=1.

Optional Feature:
- Macro: PRIORITY_MUX_ARB_LOCK_EN.
- When defined:
  - Adds input port lock (1 bit). lock is sampled together with a transfer.
  - While a transfer occurs with lock=1, the granted channel index is stored as locked.
  - While locked, gnt is forced to the locked channel if it has din_vld; otherwise gnt=0. Other requesters wait.
  - The lock releases on the first transfer with lock=0. That transfer is still from the locked channel.
  - Reset clears the lock.
  - rr_ptr updates normally on each locked transfer.
- When undefined: no lock port, and arbitration is purely per-cycle as described above.

Test Plan:
- Reset: CNT=4, WIDTH=8. Hold rst_n=0 for 2 cycles with din_vld=4'hF -> dout_vld=0, dout=0, dout_gnt=0, din_rdy=0. First cycle after release -> din_rdy=4'b0001.
- Fixed mode, din_vld=4'b1010, din[1]=8'h11, din[3]=8'h33, dout_rdy=1 -> next cycle dout=8'h11, dout_gnt=4'b0010. Channel 1 is granted every cycle while it stays valid.
- RR mode, all 4 channels valid continuously, dout_rdy=1 -> dout_gnt sequence 0001, 0010, 0100, 1000, 0001, with one word per cycle.
- Stall: dout_rdy=0 for 3 cycles after a transfer from channel 2 -> dout, dout_gnt=4'b0100 and dout_vld=1 hold, din_rdy=0. On dout_rdy=1, the next word is loaded in the same cycle.
- Wrap/idle: RR mode, rr_ptr=3, only din_vld[0]=1 -> channel 0 is granted and rr_ptr becomes 1. Then din_vld=0 with dout_rdy=1 -> dout_vld falls to 0 next cycle.
- PRIORITY_MUX_ARB_LOCK_EN: RR mode, channel 2 transfers with lock=1 for 3 beats while channels 0 and 3 request -> only channel 2 is granted. Its beat with lock=0 releases the lock, and channel 3 is granted next.
